// File: rtl/puf_resample_pkg.sv
// Shared constants for the 5:4 PUF-to-USRP linear-interpolation resampler:
// phase encoding, per-phase Q1.15 weight table and rounding constants.
package puf_resample_pkg;

   typedef enum logic [2:0] {
      PH0 = 3'd0,
      PH1 = 3'd1,
      PH2 = 3'd2,
      PH3 = 3'd3,
      PH4 = 3'd4
   } phase_e;

   localparam int WGT_W     = 17;
   localparam int Q15_ROUND = 16384;
   localparam int Q15_SHIFT = 15;

   typedef struct packed {
      logic [WGT_W-1:0] wp;
      logic [WGT_W-1:0] wc;
      logic             no_out;
   } weight_t;

   // Output positions 0, 1.25, 2.5, 3.75 fall inside phases 0, 2, 3, 4; phase 1 has none.
   localparam weight_t WEIGHT_TBL [0:4] = '{
      '{17'd0,     17'd32768, 1'b0},
      '{17'd0,     17'd0,     1'b1},
      '{17'd24576, 17'd8192,  1'b0},
      '{17'd16384, 17'd16384, 1'b0},
      '{17'd8192,  17'd24576, 1'b0}
   };

   localparam weight_t TLAST_WEIGHT = '{wp: 17'd0, wc: 17'd32768, no_out: 1'b0};

   function automatic weight_t weight_of(input phase_e ph, input logic last);
      weight_t w;
      case (ph)
         PH0:     w = WEIGHT_TBL[0];
         PH1:     w = WEIGHT_TBL[1];
         PH2:     w = WEIGHT_TBL[2];
         PH3:     w = WEIGHT_TBL[3];
         PH4:     w = WEIGHT_TBL[4];
         default: w = WEIGHT_TBL[0];
      endcase
      // A packet ending on the silent phase still emits its final sample.
      if (w.no_out && last) w = TLAST_WEIGHT;
      return w;
   endfunction

endpackage

// File: rtl/lerp_q15.sv
// Two-stage weighted sum for one signed component: products registered,
// then sum + round + >>>15 registered.
module lerp_q15
   import puf_resample_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] prev,
   input  logic signed [DATA_WIDTH-1:0] cur,
   input  logic        [WGT_W-1:0]      wp,
   input  logic        [WGT_W-1:0]      wc,
   output logic signed [DATA_WIDTH-1:0] y
);

   localparam int PW = DATA_WIDTH + WGT_W + 1;
   localparam int SW = PW + 1;

   logic signed [PW-1:0]         prod_prev_p1_d, prod_prev_p1_q;
   logic signed [PW-1:0]         prod_cur_p1_d,  prod_cur_p1_q;
   logic signed [DATA_WIDTH-1:0] y_p2_d,         y_p2_q;

   // Convex weights keep the result inside the input range, so truncation is safe.
   function automatic logic signed [DATA_WIDTH-1:0] round_q15(
      input logic signed [PW-1:0] a,
      input logic signed [PW-1:0] b
   );
      logic signed [SW-1:0] s;
      s = SW'(a) + SW'(b) + SW'(Q15_ROUND);
      return DATA_WIDTH'(s >>> Q15_SHIFT);
   endfunction

   always_comb begin
      prod_prev_p1_d = PW'(prev) * PW'($signed({1'b0, wp}));
      prod_cur_p1_d  = PW'(cur)  * PW'($signed({1'b0, wc}));
      y_p2_d         = round_q15(prod_prev_p1_q, prod_cur_p1_q);
   end

   // stage p1: products, stage p2: rounded sum
   always_ff @(posedge clk) begin
      if (!reset) begin
         prod_prev_p1_q <= '0;
         prod_cur_p1_q  <= '0;
         y_p2_q         <= '0;
      end else if (en) begin
         prod_prev_p1_q <= prod_prev_p1_d;
         prod_cur_p1_q  <= prod_cur_p1_d;
         y_p2_q         <= y_p2_d;
      end
   end

   assign y = y_p2_q;

endmodule

// File: rtl/puf2usrp.sv
// 5:4 linear-interpolation resampler from PUF rate to USRP rate on an
// AXI-Stream style I/Q interface, two-cycle latency.
module puf2usrp
   import puf_resample_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_tvalid,
   output logic                    in_tready,
   input  logic                    in_tlast,
   input  logic [2*DATA_WIDTH-1:0] in_tdata,
   output logic                    out_tvalid,
   input  logic                    out_tready,
   output logic                    out_tlast,
   output logic [2*DATA_WIDTH-1:0] out_tdata
);

   localparam int W = DATA_WIDTH;

   phase_e           phase_d, phase_q;
   logic [2*W-1:0]   prev_d, prev_q;
   logic             vld_p1_d, vld_p1_q, last_p1_d, last_p1_q;
   logic             vld_p2_d, vld_p2_q, last_p2_d, last_p2_q;
   logic             en, accept;
   weight_t          w;
   logic signed [W-1:0] y_i, y_q;

   always_comb begin
      // The whole pipeline advances together; reset also counts as "ready".
      en        = ~vld_p2_q | out_tready | ~reset;
      accept    = in_tvalid & en;
      w         = weight_of(phase_q, in_tlast);

      phase_d   = phase_q;
      prev_d    = prev_q;
      vld_p1_d  = vld_p1_q;
      last_p1_d = last_p1_q;
      vld_p2_d  = vld_p2_q;
      last_p2_d = last_p2_q;

      if (en) begin
         vld_p1_d  = accept & ~w.no_out;
         last_p1_d = accept & in_tlast;
         vld_p2_d  = vld_p1_q;
         last_p2_d = last_p1_q;
      end

      if (accept) begin
         if (in_tlast) begin
            phase_d = PH0;
            prev_d  = '0;
         end else begin
            prev_d  = in_tdata;
            phase_d = (phase_q == PH4) ? PH0 : phase_e'(phase_q + 3'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q   <= PH0;
         prev_q    <= '0;
         vld_p1_q  <= 1'b0;
         last_p1_q <= 1'b0;
         vld_p2_q  <= 1'b0;
         last_p2_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         prev_q    <= prev_d;
         vld_p1_q  <= vld_p1_d;
         last_p1_q <= last_p1_d;
         vld_p2_q  <= vld_p2_d;
         last_p2_q <= last_p2_d;
      end
   end

   lerp_q15 #(.DATA_WIDTH(W)) u_lerp_i (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .prev  (prev_q[2*W-1:W]),
      .cur   (in_tdata[2*W-1:W]),
      .wp    (w.wp),
      .wc    (w.wc),
      .y     (y_i)
   );

   lerp_q15 #(.DATA_WIDTH(W)) u_lerp_q (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .prev  (prev_q[W-1:0]),
      .cur   (in_tdata[W-1:0]),
      .wp    (w.wp),
      .wc    (w.wc),
      .y     (y_q)
   );

   assign in_tready  = en;
   assign out_tvalid = vld_p2_q;
   assign out_tlast  = last_p2_q;
   assign out_tdata  = {y_i, y_q};

endmodule

// File: tb/tb_puf2usrp.sv
// Directed + randomized bench for puf2usrp against a position-based
// interpolation model (output j of each 5-sample group sits at 1.25*j).
module tb_puf2usrp;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           in_tvalid = 1'b0;
   logic           in_tready;
   logic           in_tlast = 1'b0;
   logic [2*W-1:0] in_tdata = '0;
   logic           out_tvalid;
   logic           out_tready = 1'b0;
   logic           out_tlast;
   logic [2*W-1:0] out_tdata;

   always #5 clk = ~clk;

   puf2usrp #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .in_tlast   (in_tlast),
      .in_tdata   (in_tdata),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tlast  (out_tlast),
      .out_tdata  (out_tdata)
   );

   typedef struct { int i; int q; bit last; } samp_t;
   typedef struct { int i; int q; bit last; int cyc; } exp_t;

   int    n_assert = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   samp_t stim[$];
   exp_t  expq[$];
   int    got_i[$];
   int    got_q[$];
   int    got_l[$];
   int    gi[5];
   int    gq[5];
   int    gidx = 0;

   task automatic check(input string tag, input longint obs, input longint expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Value at fractional position lo + f/4 between a and b, Q15 rounded.
   function automatic int interp(input int a, input int b, input int f);
      longint acc;
      acc = longint'(a) * (4 - f) * 8192 + longint'(b) * f * 8192 + 16384;
      return int'(acc >>> 15);
   endfunction

   function automatic void emit(input int i, input int q, input bit last);
      exp_t e;
      e.i = i; e.q = q; e.last = last; e.cyc = cyc;
      expq.push_back(e);
   endfunction

   function automatic void model_accept(input int i, input int q, input bit last);
      int p, j, lo, f;
      p = gidx;
      gi[p] = i;
      gq[p] = q;
      if (p == 0) begin
         emit(i, q, last);
      end else if (p == 1) begin
         if (last) emit(i, q, 1'b1);
      end else begin
         j  = p - 1;
         lo = (5 * j) / 4;
         f  = (5 * j) % 4;
         emit(interp(gi[lo], gi[lo+1], f), interp(gq[lo], gq[lo+1], f), last);
      end
      gidx = last ? 0 : (p + 1) % 5;
   endfunction

   function automatic void add_ramp(input int start, input int step, input int n, input bit tl);
      samp_t s;
      for (int k = 0; k < n; k++) begin
         s.i = start + k * step;
         s.q = s.i;
         s.last = tl && (k == n - 1);
         stim.push_back(s);
      end
   endfunction

   // rdy_mode: 0 always ready, 1 toggling, 2 random. gap < 0 picks random gaps.
   task automatic stream(input string tag, input int gap, input int rdy_mode, input bit chk_lat);
      int             k, idle, budget, ti, tq, oi, oq;
      bit             stalled, held_last;
      logic [2*W-1:0] held;
      exp_t           e;
      k = 0; idle = 0; budget = 0; stalled = 0; held = '0; held_last = 0;
      got_i.delete(); got_q.delete(); got_l.delete();
      while ((k < stim.size() || expq.size() > 0) && budget < 5000) begin
         @(negedge clk);
         if (k < stim.size() && idle == 0) begin
            ti = stim[k].i;
            tq = stim[k].q;
            in_tvalid = 1'b1;
            in_tdata  = {ti[W-1:0], tq[W-1:0]};
            in_tlast  = stim[k].last;
         end else begin
            in_tvalid = 1'b0;
            in_tlast  = 1'b0;
         end
         case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = cyc[0];
            default: out_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (stalled) begin
            check({tag, "_stall_data"}, out_tdata, held);
            check({tag, "_stall_last"}, out_tlast, held_last);
            check({tag, "_stall_vld"}, out_tvalid, 1);
         end
         check({tag, "_in_tready"}, in_tready, (!out_tvalid) || out_tready);
         if (out_tvalid && out_tready) begin
            oi = int'($signed(out_tdata[2*W-1:W]));
            oq = int'($signed(out_tdata[W-1:0]));
            if (expq.size() == 0) begin
               check({tag, "_extra_out"}, out_tvalid, 0);
            end else begin
               e = expq.pop_front();
               check({tag, "_out_i"}, oi, e.i);
               check({tag, "_out_q"}, oq, e.q);
               check({tag, "_out_last"}, out_tlast, e.last);
               if (chk_lat) check({tag, "_latency"}, cyc, e.cyc + 2);
            end
            got_i.push_back(oi);
            got_q.push_back(oq);
            got_l.push_back(int'(out_tlast));
         end
         stalled   = out_tvalid && !out_tready;
         held      = out_tdata;
         held_last = out_tlast;
         if (in_tvalid && in_tready) begin
            model_accept(stim[k].i, stim[k].q, stim[k].last);
            k++;
            idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         end else if (!in_tvalid && idle > 0) begin
            idle--;
         end
         cyc++;
         budget++;
      end
      check({tag, "_drained"}, expq.size() + (stim.size() - k), 0);
      @(negedge clk);
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      stim.delete();
   endtask

   int ramp_exp[8] = '{0, 125, 250, 375, 500, 625, 750, 875};
   int pkt_exp[6]  = '{0, 125, 250, 375, 500, 600};

   initial begin
      samp_t s;
      int    ti;

      // Reset state
      out_tready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_tvalid", out_tvalid, 0);
      check("rst_out_tlast", out_tlast, 0);
      check("rst_out_tdata", out_tdata, 0);
      check("rst_in_tready", in_tready, 1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_in_tready", in_tready, 1);

      // Ramp with continuous flow
      add_ramp(0, 100, 10, 1'b0);
      stream("ramp", 0, 0, 1'b1);
      check("ramp_count", got_i.size(), 8);
      for (int k = 0; k < 8 && k < got_i.size(); k++) begin
         check("ramp_i", got_i[k], ramp_exp[k]);
         check("ramp_q", got_q[k], ramp_exp[k]);
      end

      // Full-scale constants must not wrap
      for (int k = 0; k < 5; k++) begin
         s.i = 32767; s.q = -32768; s.last = 1'b0;
         stim.push_back(s);
      end
      stream("const", 0, 0, 1'b1);
      check("const_count", got_i.size(), 4);
      for (int k = 0; k < got_i.size(); k++) begin
         check("const_i", got_i[k], 32767);
         check("const_q", got_q[k], -32768);
      end

      // Back-pressure with toggling ready
      for (int k = 0; k < 20; k++) begin
         s.i = int'($urandom_range(0, 65535)) - 32768;
         s.q = int'($urandom_range(0, 65535)) - 32768;
         s.last = 1'b0;
         stim.push_back(s);
      end
      stream("toggle", 0, 1, 1'b0);
      check("toggle_count", got_i.size(), 16);

      // Packet ending on the silent phase, then a fresh packet
      add_ramp(0, 100, 7, 1'b1);
      stream("pkt", 0, 0, 1'b1);
      check("pkt_count", got_i.size(), 6);
      for (int k = 0; k < 6 && k < got_i.size(); k++) begin
         check("pkt_i", got_i[k], pkt_exp[k]);
         check("pkt_last", got_l[k], (k == 5) ? 1 : 0);
      end
      add_ramp(1000, 100, 5, 1'b0);
      stream("pkt2", 0, 0, 1'b1);
      check("pkt2_first", (got_i.size() > 0) ? got_i[0] : -1, 1000);

      // Idle gaps between samples
      add_ramp(0, 100, 10, 1'b0);
      stream("gap", 3, 0, 1'b1);
      check("gap_count", got_i.size(), 8);
      for (int k = 0; k < 8 && k < got_i.size(); k++)
         check("gap_i", got_i[k], ramp_exp[k]);

      // Reset mid-packet
      out_tready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ti = 7 + k;
         in_tvalid = 1'b1;
         in_tlast  = 1'b0;
         in_tdata  = {ti[W-1:0], ti[W-1:0]};
      end
      @(negedge clk);
      in_tvalid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_out_tvalid", out_tvalid, 0);
      check("midrst_out_tdata", out_tdata, 0);
      check("midrst_in_tready", in_tready, 1);
      @(negedge clk);
      reset = 1'b1;
      expq.delete();
      gidx = 0;
      #1;
      check("midrst_no_partial", out_tvalid, 0);
      add_ramp(0, 100, 10, 1'b0);
      stream("after_rst", 0, 0, 1'b1);
      check("after_rst_count", got_i.size(), 8);
      for (int k = 0; k < 8 && k < got_i.size(); k++)
         check("after_rst_i", got_i[k], ramp_exp[k]);

      // Randomized traffic with random ready, gaps and packet ends
      for (int k = 0; k < 80; k++) begin
         s.i = int'($urandom_range(0, 65535)) - 32768;
         s.q = int'($urandom_range(0, 65535)) - 32768;
         s.last = ($urandom_range(0, 7) == 0);
         stim.push_back(s);
      end
      stream("rand", -1, 2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
